// File: rtl/input_conditioner.sv
// Input conditioner for the board pushbuttons and slider switches.
// Every raw input is synchronized, then debounced by its own counter. Pushbuttons
// also get one-cycle press/release pulses.
// Defining KEY_AUTOREPEAT_EN adds a per-key auto-repeat FSM. That FSM emits extra
// key_press pulses while a key stays held.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] key_raw,
    input  logic [9:0] sw_raw,
    output logic [3:0] pushbuttons_export,
    output logic [9:0] slider_switches_export,
    output logic [3:0] key_press,
    output logic [3:0] key_release
);

    localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_ALL = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
    localparam int          CW      = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere: {switches[9:0], keys[3:0]}
    logic [13:0]   sync1_q, sync1_d;
    logic [13:0]   sync2_q, sync2_d;
    logic [1:0]    warm_q, warm_d;
    logic [13:0]   level_q, level_d;
    logic [CW-1:0] cnt_q [14];
    logic [CW-1:0] cnt_d [14];
    logic [3:0]    press_q, press_d;
    logic [3:0]    release_q, release_d;
    logic [13:0]   cond;
    logic [3:0]    key_rise, key_fall;
    logic [3:0]    rpt_pulse;

    // Two-flop synchronizer input.
    // warm marks when the second stage holds a real sample again after reset, so the
    // cleared synchronizer contents are never mistaken for a pressed key.
    always_comb begin
        sync1_d = {sw_raw, key_raw};
        sync2_d = sync1_q;
        warm_d  = {warm_q[0], 1'b1};
    end

    // Per-input debounce.
    // A level is accepted only after it has differed from the current debounced level
    // for DEBOUNCE_CYCLES consecutive cycles. Any agreement clears the count.
    always_comb begin
        cond    = {sync2_q[13:4], ~sync2_q[3:0]};
        level_d = level_q;
        for (int i = 0; i < 14; i++) begin
            cnt_d[i] = '0;
            if (warm_q[1] && (cond[i] != level_q[i])) begin
                if (cnt_q[i] >= DEB_LAST) begin
                    level_d[i] = cond[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Press/release pulses, registered in the same cycle the debounced key level changes
    always_comb begin
        key_rise  = level_d[3:0] & ~level_q[3:0];
        key_fall  = level_q[3:0] & ~level_d[3:0];
        press_d   = key_rise | rpt_pulse;
        release_d = key_fall;
    end

`ifdef KEY_AUTOREPEAT_EN
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

    localparam logic [CW-1:0] DELAY_LAST = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RATE_LAST  = CW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

    rpt_state_e    rpt_state_q [4];
    rpt_state_e    rpt_state_d [4];
    logic [CW-1:0] rpt_cnt_q [4];
    logic [CW-1:0] rpt_cnt_d [4];

    // Auto-repeat next state.
    // A release always wins, so a repeat pulse never collides with a release pulse.
    always_comb begin
        rpt_pulse = '0;
        for (int k = 0; k < 4; k++) begin
            rpt_state_d[k] = rpt_state_q[k];
            rpt_cnt_d[k]   = rpt_cnt_q[k];
            if (key_fall[k]) begin
                rpt_state_d[k] = RPT_IDLE;
                rpt_cnt_d[k]   = '0;
            end else if (key_rise[k]) begin
                rpt_state_d[k] = RPT_DELAY;
                rpt_cnt_d[k]   = '0;
            end else begin
                case (rpt_state_q[k])
                    RPT_DELAY: begin
                        if (rpt_cnt_q[k] >= DELAY_LAST) begin
                            rpt_pulse[k]   = 1'b1;
                            rpt_state_d[k] = RPT_REPEAT;
                            rpt_cnt_d[k]   = '0;
                        end else begin
                            rpt_cnt_d[k] = rpt_cnt_q[k] + CW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt_q[k] >= RATE_LAST) begin
                            rpt_pulse[k] = 1'b1;
                            rpt_cnt_d[k] = '0;
                        end else begin
                            rpt_cnt_d[k] = rpt_cnt_q[k] + CW'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[k] = RPT_IDLE;
                        rpt_cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    // Auto-repeat state register; reset abandons any repeat in progress
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < 4; k++) begin
                rpt_state_q[k] <= RPT_IDLE;
                rpt_cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                rpt_state_q[k] <= rpt_state_d[k];
                rpt_cnt_q[k]   <= rpt_cnt_d[k];
            end
        end
    end
`else
    // No auto-repeat: key_press only reflects accepted presses
    always_comb begin
        rpt_pulse = '0;
    end
`endif

    // Main state register: synchronizers, debounce counters, levels and pulses
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            warm_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 14; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            warm_q    <= warm_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 14; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pushbuttons_export     = level_q[3:0];
    assign slider_switches_export = level_q[13:4];
    assign key_press              = press_q;
    assign key_release            = release_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner, built with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_RATE=5.
// Expected auto-repeat behaviour follows KEY_AUTOREPEAT_EN.
module tb_input_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 5;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b0;
    logic [3:0] keyRaw = 4'hF;
    logic [9:0] swRaw  = 10'h000;
    logic [3:0] pushbuttons;
    logic [9:0] switches;
    logic [3:0] keyPress;
    logic [3:0] keyRelease;

    int total = 0;
    int bad   = 0;

    // Reference model state. Inputs are ordered {switches, keys (1 = pressed)}.
    logic [13:0] mLevel;
    int          mRun [14];
    logic [13:0] rawQ [$];
    logic [3:0]  mPress;
    logic [3:0]  mRelease;
    int          edgeNo = 0;
    int          pressEdge [4];

    typedef struct {
        logic [3:0] key;
        logic [9:0] sw;
        int         hold;
        logic [3:0] expPb;
        logic [9:0] expSw;
    } vec_t;

    vec_t vecs [8];

    input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk_clk               (clk),
        .reset_reset_n         (rstN),
        .key_raw               (keyRaw),
        .sw_raw                (swRaw),
        .pushbuttons_export    (pushbuttons),
        .slider_switches_export(switches),
        .key_press             (keyPress),
        .key_release           (keyRelease)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at edge %0d", name, actual, expected, edgeNo);
        end
    endtask

    function automatic void modelReset();
        mLevel   = '0;
        mPress   = '0;
        mRelease = '0;
        rawQ.delete();
        for (int i = 0; i < 14; i++) mRun[i] = 0;
    endfunction

    // A sampled value reaches the debouncer two edges later.
    // A level is accepted once the value has disagreed with it on DEB consecutive edges.
    // Repeats fall RD edges after the press, then every RR edges while the key stays down.
    task automatic modelEdge();
        logic [13:0] syn;
        logic [13:0] prev;
        int h;
        edgeNo++;
        if (!rstN) begin
            modelReset();
            return;
        end
        prev = mLevel;
        if (rawQ.size() >= 2) begin
            syn = rawQ.pop_front();
            for (int i = 0; i < 14; i++) begin
                if (syn[i] != mLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DEB) begin
                        mLevel[i] = syn[i];
                        mRun[i]   = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
        end
        rawQ.push_back({swRaw, ~keyRaw});
        mPress   = mLevel[3:0] & ~prev[3:0];
        mRelease = prev[3:0] & ~mLevel[3:0];
        for (int k = 0; k < 4; k++) begin
            if (mPress[k]) begin
                pressEdge[k] = edgeNo;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (mLevel[k]) begin
                h = edgeNo - pressEdge[k];
                if (h == RD || (h > RD && ((h - RD) % RR) == 0)) mPress[k] = 1'b1;
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model", 32'({pushbuttons, switches, keyPress, keyRelease}),
                    32'({mLevel[3:0], mLevel[13:4], mPress, mRelease}));
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic [9:0] s);
        keyRaw = k;
        swRaw  = s;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic assertReset();
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("resetOut", 32'({pushbuttons, switches, keyPress, keyRelease}), 32'd0);
    endtask

    initial begin
        int pressCnt;
        int relCnt;
        int expPressCnt;
        logic expP;

        vecs[0] = '{4'hF, 10'h000, 8, 4'h0, 10'h000};
        vecs[1] = '{4'h7, 10'h155, 8, 4'h8, 10'h155};
        vecs[2] = '{4'hF, 10'h155, 3, 4'h8, 10'h155};
        vecs[3] = '{4'h7, 10'h155, 8, 4'h8, 10'h155};
        vecs[4] = '{4'h0, 10'h2AA, 8, 4'hF, 10'h2AA};
        vecs[5] = '{4'hF, 10'h000, 8, 4'h0, 10'h000};
        vecs[6] = '{4'hF, 10'h001, 2, 4'h0, 10'h000};
        vecs[7] = '{4'hF, 10'h000, 8, 4'h0, 10'h000};

        modelReset();
        #1;
        checkOutput("resetOut", 32'({pushbuttons, switches, keyPress, keyRelease}), 32'd0);
        settle(3);
        rstN = 1'b1;
        settle(10);

        $display("[TB] table vectors");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].key, vecs[v].sw);
            settle(vecs[v].hold);
            checkOutput("vecPb", 32'(pushbuttons), 32'(vecs[v].expPb));
            checkOutput("vecSw", 32'(switches), 32'(vecs[v].expSw));
        end

        $display("[TB] single clean press and release");
        applyStimulus(4'hE, 10'h000);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput("pressPb0", 32'(pushbuttons[0]), 32'(c >= 6));
            checkOutput("pressPulse0", 32'(keyPress[0]), 32'(c == 6));
        end
        applyStimulus(4'hF, 10'h000);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput("releasePulse0", 32'(keyRelease[0]), 32'(c == 6));
        end

        $display("[TB] bouncing switch");
        applyStimulus(4'hF, 10'h008);
        settle(2);
        checkOutput("bounceSw3", 32'(switches[3]), 32'd0);
        applyStimulus(4'hF, 10'h000);
        settle(2);
        checkOutput("bounceSw3", 32'(switches[3]), 32'd0);
        applyStimulus(4'hF, 10'h008);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput("bounceSw3", 32'(switches[3]), 32'(c >= 6));
        end
        applyStimulus(4'hF, 10'h000);
        settle(8);

        $display("[TB] simultaneous edges on all inputs");
        applyStimulus(4'h0, 10'h3FF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput("allPb", 32'(pushbuttons), (c >= 6) ? 32'hF : 32'h0);
            checkOutput("allSw", 32'(switches), (c >= 6) ? 32'h3FF : 32'h0);
            checkOutput("allPress", 32'(keyPress), (c == 6) ? 32'hF : 32'h0);
        end
        applyStimulus(4'hF, 10'h000);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput("allRelease", 32'(keyRelease), (c == 6) ? 32'hF : 32'h0);
        end

        $display("[TB] reset mid-debounce");
        applyStimulus(4'hE, 10'h000);
        settle(4);
        assertReset();
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkOutput("inReset", 32'({pushbuttons, switches, keyPress, keyRelease}), 32'd0);
        end
        rstN = 1'b1;
        pressCnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checkOutput("postResetPress", 32'(keyPress[0]), 32'(c == 6));
            pressCnt += int'(keyPress[0]);
        end
        checkOutput("postResetPressCnt", 32'(pressCnt), 32'd1);
        applyStimulus(4'hF, 10'h000);
        settle(10);

        $display("[TB] long hold");
        applyStimulus(4'hE, 10'h000);
        pressCnt = 0;
        relCnt   = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
`ifdef KEY_AUTOREPEAT_EN
            expP = (c == 6 || c == 16 || c == 21 || c == 26 || c == 31);
`else
            expP = (c == 6);
`endif
            checkOutput("holdPress", 32'(keyPress[0]), 32'(expP));
            checkOutput("holdRelease", 32'(keyRelease[0]), 32'(c == 36));
            pressCnt += int'(keyPress[0]);
            relCnt   += int'(keyRelease[0]);
            if (c == 30) applyStimulus(4'hF, 10'h000);
        end
`ifdef KEY_AUTOREPEAT_EN
        expPressCnt = 5;
`else
        expPressCnt = 1;
`endif
        checkOutput("holdPressCnt", 32'(pressCnt), 32'(expPressCnt));
        checkOutput("holdReleaseCnt", 32'(relCnt), 32'd1);

        $display("[TB] random stimulus");
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) applyStimulus(4'($urandom), 10'($urandom));
            if (n == 300) assertReset();
            if (n == 303) rstN = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable clock cycles required before an input change is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of cycles a key is held before its first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 5000000, is the number of cycles between subsequent auto-repeat pulses.
REQ-004 Port clk_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset_reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port key_raw, input, 4 bits: board pushbuttons, active-low, asynchronous to clk_clk.
REQ-007 Port sw_raw, input, 10 bits: board slider switches, asynchronous to clk_clk.
REQ-008 Port pushbuttons_export, output, 4 bits: debounced pushbutton level, active-high (1 = pressed), feeding the system pushbutton PIO.
REQ-009 Port slider_switches_export, output, 10 bits: debounced switch level, feeding the system switch PIO.
REQ-010 Port key_press, output, 4 bits: one-cycle pulse per key on an accepted press, or on an auto-repeat.
REQ-011 Port key_release, output, 4 bits: one-cycle pulse per key on an accepted release.

Function
REQ-012 Each of the 14 raw inputs shall pass through a 2-flop synchronizer; key_raw shall be inverted after synchronization.
REQ-013 Each input shall have its own debounce counter; the counter clears whenever the synchronized value equals the current debounced value.
REQ-014 While the synchronized value differs from the debounced value, the counter shall increment; when it reaches DEBOUNCE_CYCLES-1, the debounced value shall take the synchronized value on the next edge and the counter shall clear.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles shall never change the debounced output, and any bounce shall restart the count from zero.
REQ-016 Latency shall be exactly 2 + DEBOUNCE_CYCLES cycles from a clean raw edge to the debounced output change.
REQ-017 key_press[i] shall assert for exactly one cycle in the same cycle pushbuttons_export[i] rises 0->1; key_release[i] shall do the same when it falls 1->0.
REQ-018 key_press and key_release for the same key shall never be high in the same cycle.
REQ-019 Simultaneous transitions on different inputs shall be processed independently, with no arbitration and no lost pulses.
REQ-020 Counters shall saturate and never wrap; the counter width shall be clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)).

Reset
REQ-021 Asserting reset_reset_n low shall immediately clear all synchronizers, counters and debounced levels to 0.
REQ-022 During reset, pushbuttons_export, slider_switches_export, key_press and key_release shall all be 0.
REQ-023 After reset is released, an input that is already active shall be reported as a normal press after 2 + DEBOUNCE_CYCLES cycles, so a key held through reset produces one key_press.
REQ-024 Reset asserted mid-debounce or mid-repeat shall abandon that operation; no pulse shall be emitted for it.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN shall control auto-repeat.
- Defined: each key has a per-key repeat FSM with states IDLE, DELAY, REPEAT.
- IDLE->DELAY on an accepted press.
- DELAY->REPEAT after REPEAT_DELAY cycles held, emitting one key_press pulse.
- In REPEAT, one key_press pulse every REPEAT_RATE cycles.
- Any state->IDLE on an accepted release.
- Undefined: no repeat logic exists, and key_press fires only on accepted presses.
- REPEAT_DELAY and REPEAT_RATE are ignored when the macro is undefined.

Verification
REQ-026 DEBOUNCE_CYCLES=4; key_raw[0] falls cleanly at cycle 0 -> pushbuttons_export[0]=1 and key_press[0] pulses once at cycle 6.
REQ-027 DEBOUNCE_CYCLES=4; sw_raw[3] toggles 1,0,1 with 2-cycle gaps, then holds 1 -> a single output rise, 6 cycles after the last toggle, with no intermediate change.
REQ-028 DEBOUNCE_CYCLES=4; key_raw=4'b0000 and sw_raw=10'h3FF change in the same cycle -> all 14 outputs update in the same cycle, with 4 key_press pulses.
REQ-029 reset_reset_n pulled low at debounce count 2 and released 3 cycles later while the key is still held -> no output during reset; key_press pulses 6 cycles after release.
REQ-030 KEY_AUTOREPEAT_EN defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5; key held 30 cycles -> key_press pulses at cycles 6, 16, 21, 26, 31, then key_release once after release plus 6 cycles.
REQ-031 KEY_AUTOREPEAT_EN undefined, same stimulus as REQ-030 -> exactly one key_press and one key_release.
